// File: rtl/muldiv_control_if.sv
// rtl/muldiv_control_if.sv - id_ex request / ex result bundle for the mul/div unit
interface muldiv_control_if;
    logic        id_ex_mdstart;
    logic [2:0]  id_ex_mdop;
    logic [1:0]  id_ex_mfhilo;
    logic [31:0] id_ex_rega;
    logic [31:0] id_ex_regb;
    logic [31:0] ex_md_hi;
    logic [31:0] ex_md_lo;
    logic [31:0] ex_md_readvalue;
    logic        ex_md_busy;
    logic        ex_md_divzero;
    logic        ex_if_stall;

    modport master (
        output id_ex_mdstart, id_ex_mdop, id_ex_mfhilo, id_ex_rega, id_ex_regb,
        input  ex_md_hi, ex_md_lo, ex_md_readvalue, ex_md_busy, ex_md_divzero, ex_if_stall
    );

    modport slave (
        input  id_ex_mdstart, id_ex_mdop, id_ex_mfhilo, id_ex_rega, id_ex_regb,
        output ex_md_hi, ex_md_lo, ex_md_readvalue, ex_md_busy, ex_md_divzero, ex_if_stall
    );
endinterface

// File: rtl/muldiv_control.sv
// rtl/muldiv_control.sv - iterative 32-step multiply/divide unit with HI/LO registers
module muldiv_control (
    input  logic             clock,
    input  logic             reset,
    muldiv_control_if.slave  md
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic        neg_q;
    logic        rneg_q;
    logic        div_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        divzero_q;

    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] mul_res;

    assign op_signed = (md.id_ex_mdop == 3'b001) || (md.id_ex_mdop == 3'b011);
    assign mag_a     = (op_signed && md.id_ex_rega[31]) ? (32'd0 - md.id_ex_rega) : md.id_ex_rega;
    assign mag_b     = (op_signed && md.id_ex_regb[31]) ? (32'd0 - md.id_ex_regb) : md.id_ex_regb;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
    assign div_trial = acc_q[63:31] - {1'b0, opb_q};
    assign mul_res   = neg_q ? (64'd0 - acc_q) : acc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (md.id_ex_mdstart) begin
                        case (md.id_ex_mdop)
                            3'b001, 3'b010: begin
                                acc_q   <= {32'd0, mag_b};
                                opb_q   <= mag_a;
                                neg_q   <= op_signed & (md.id_ex_rega[31] ^ md.id_ex_regb[31]);
                                rneg_q  <= 1'b0;
                                div_q   <= 1'b0;
                                count_q <= 5'd0;
                                state_q <= S_MUL;
                            end
                            3'b011, 3'b100: begin
                                if (md.id_ex_regb == 32'd0) begin
                                    hi_q      <= md.id_ex_rega;
                                    lo_q      <= 32'hFFFF_FFFF;
                                    divzero_q <= 1'b1;
                                    state_q   <= S_DONE;
                                end else begin
                                    acc_q   <= {32'd0, mag_a};
                                    opb_q   <= mag_b;
                                    neg_q   <= op_signed & (md.id_ex_rega[31] ^ md.id_ex_regb[31]);
                                    rneg_q  <= op_signed & md.id_ex_rega[31];
                                    div_q   <= 1'b1;
                                    count_q <= 5'd0;
                                    state_q <= S_DIV;
                                end
                            end
                            3'b101:  hi_q <= md.id_ex_rega;
                            3'b110:  lo_q <= md.id_ex_rega;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q   <= {mul_sum, acc_q[31:1]};
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) state_q <= S_FIX;
                end
                S_DIV: begin
                    if (!div_trial[32]) acc_q <= {div_trial[31:0], acc_q[30:0], 1'b1};
                    else                acc_q <= {acc_q[62:0], 1'b0};
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (div_q) begin
                        lo_q <= neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                        hi_q <= rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    end else begin
                        hi_q <= mul_res[63:32];
                        lo_q <= mul_res[31:0];
                    end
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign md.ex_md_hi      = hi_q;
    assign md.ex_md_lo      = lo_q;
    assign md.ex_md_busy    = (state_q != S_IDLE);
    assign md.ex_md_divzero = divzero_q;
    assign md.ex_if_stall   = md.ex_md_busy & (md.id_ex_mdstart | (md.id_ex_mfhilo != 2'b00));

    always_comb begin
        md.ex_md_readvalue = 32'd0;
        case (md.id_ex_mfhilo)
            2'b01:   md.ex_md_readvalue = hi_q;
            2'b10:   md.ex_md_readvalue = lo_q;
            default: md.ex_md_readvalue = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_muldiv_control.sv
// tb/tb_muldiv_control.sv - scoreboard bench for muldiv_control
module tb_muldiv_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    muldiv_control_if md();
    muldiv_control dut (.clock(clock), .reset(reset), .md(md));

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint      sp;
        int          sq;
        int          sr;
        r = 64'd0;
        case (op)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); r = sp; end
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); r = {sr, sq}; end
            end
            3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic drive_idle();
        md.id_ex_mdstart = 1'b0;
        md.id_ex_mdop    = 3'd0;
        md.id_ex_mfhilo  = 2'd0;
        md.id_ex_rega    = 32'd0;
        md.id_ex_regb    = 32'd0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        md.id_ex_mdstart = 1'b1;
        md.id_ex_mdop    = op;
        md.id_ex_rega    = a;
        md.id_ex_regb    = b;
        if (op >= 3'd1 && op <= 3'd4) exp_q.push_back(model(op, a, b));
        @(negedge clock);
        md.id_ex_mdstart = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (md.ex_md_busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {md.ex_md_hi, md.ex_md_lo}); end
        checks++; if ({md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero}); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if ({md.ex_md_hi, md.ex_md_lo, md.ex_md_readvalue} !== 96'd0) begin errors++; $display("FAIL post_reset_regs: got %h expected 0", {md.ex_md_hi, md.ex_md_lo, md.ex_md_readvalue}); end
        checks++; if ({md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero} !== 3'b000) begin errors++; $display("FAIL post_reset_flags: got %b expected 000", {md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero}); end
    endtask

    task automatic test_multu();
        int cyc;
        logic [63:0] e;
        issue(3'd2, 32'd7, 32'd6);
        wait_idle(cyc);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 34", cyc); end
        e = exp_q.pop_front();
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL multu_result: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
        checks++; if (md.ex_md_lo !== 32'd42) begin errors++; $display("FAIL multu_lo42: got %0d expected 42", md.ex_md_lo); end
    endtask

    task automatic test_signed();
        logic [2:0]  ops[8] = '{3'd1, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [31:0] as[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] bs[8]  = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd3, 32'd7};
        int cyc;
        logic [63:0] e;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) issue(ops[i], as[i], bs[i]);
            else issue(3'($urandom_range(1, 4)), 32'($urandom), 32'($urandom));
            wait_idle(cyc);
            e = exp_q.pop_front();
            checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL arith_%0d: got %h expected %h", i, {md.ex_md_hi, md.ex_md_lo}, e); end
            if (i == 0) begin
                checks++; if ({md.ex_md_hi, md.ex_md_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg3x5: got %h expected ffffffff_fffffff1", {md.ex_md_hi, md.ex_md_lo}); end
            end
            if (i == 1) begin
                checks++; if ({md.ex_md_hi, md.ex_md_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg7by2: got %h expected ffffffff_fffffffd", {md.ex_md_hi, md.ex_md_lo}); end
            end
            if (i == 2) begin
                checks++; if ({md.ex_md_hi, md.ex_md_lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 00000000_80000000", {md.ex_md_hi, md.ex_md_lo}); end
            end
        end
    endtask

    task automatic test_stall();
        int cyc;
        int bad;
        logic [63:0] e;
        issue(3'd2, 32'd3, 32'd4);
        md.id_ex_mfhilo = 2'b10;
        #1;
        checks++; if (md.ex_if_stall !== 1'b1) begin errors++; $display("FAIL stall_on_mflo: got %b expected 1", md.ex_if_stall); end
        bad = 0;
        cyc = 0;
        while (md.ex_md_busy === 1'b1 && cyc < 200) begin
            if (md.ex_if_stall !== 1'b1) bad++;
            cyc++;
            @(negedge clock);
            #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_held: got %0d unstalled busy cycles expected 0", bad); end
        checks++; if (md.ex_if_stall !== 1'b0 || md.ex_md_readvalue !== 32'd12) begin errors++; $display("FAIL mflo_after_busy: got stall=%b value=%0d expected stall=0 value=12", md.ex_if_stall, md.ex_md_readvalue); end
        e = exp_q.pop_front();
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL stall_result: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
        md.id_ex_mfhilo = 2'b00;

        issue(3'd2, 32'd5, 32'd6);
        repeat (3) @(negedge clock);
        md.id_ex_mdstart = 1'b1;
        md.id_ex_mdop    = 3'd2;
        md.id_ex_rega    = 32'd7;
        md.id_ex_regb    = 32'd8;
        #1;
        checks++; if (md.ex_if_stall !== 1'b1) begin errors++; $display("FAIL stall_on_start: got %b expected 1", md.ex_if_stall); end
        wait_idle(cyc);
        e = exp_q.pop_front();
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL busy_start_ignored: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
        exp_q.push_back(model(3'd2, 32'd7, 32'd8));
        @(negedge clock);
        checks++; if (md.ex_md_busy !== 1'b1) begin errors++; $display("FAIL held_start_accepted: got busy=%b expected 1", md.ex_md_busy); end
        md.id_ex_mdstart = 1'b0;
        wait_idle(cyc);
        e = exp_q.pop_front();
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL held_start_result: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
    endtask

    task automatic test_divzero();
        logic [63:0] e;
        issue(3'd4, 32'd9, 32'd0);
        e = exp_q.pop_front();
        checks++; if (md.ex_md_divzero !== 1'b1 || md.ex_md_busy !== 1'b1) begin errors++; $display("FAIL divzero_pulse: got divzero=%b busy=%b expected 1 1", md.ex_md_divzero, md.ex_md_busy); end
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e) begin errors++; $display("FAIL divzero_hilo: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
        @(negedge clock);
        checks++; if (md.ex_md_divzero !== 1'b0 || md.ex_md_busy !== 1'b0) begin errors++; $display("FAIL divzero_end: got divzero=%b busy=%b expected 0 0", md.ex_md_divzero, md.ex_md_busy); end
        md.id_ex_mdstart = 1'b1;
        md.id_ex_mdop    = 3'd5;
        md.id_ex_rega    = 32'h1234;
        md.id_ex_mfhilo  = 2'b01;
        #1;
        checks++; if (md.ex_if_stall !== 1'b0 || md.ex_md_readvalue !== 32'd9) begin errors++; $display("FAIL mthi_same_cycle_read: got stall=%b value=%h expected 0 9", md.ex_if_stall, md.ex_md_readvalue); end
        @(negedge clock);
        md.id_ex_mdop = 3'd6;
        md.id_ex_rega = 32'hABCD;
        checks++; if (md.ex_md_hi !== 32'h1234 || md.ex_md_busy !== 1'b0) begin errors++; $display("FAIL mthi: got hi=%h busy=%b expected 1234 0", md.ex_md_hi, md.ex_md_busy); end
        @(negedge clock);
        drive_idle();
        checks++; if (md.ex_md_lo !== 32'hABCD || md.ex_md_hi !== 32'h1234) begin errors++; $display("FAIL mtlo: got hi=%h lo=%h expected 1234 abcd", md.ex_md_hi, md.ex_md_lo); end
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [63:0] e;
        issue(3'd1, 32'hFFFF_FFFB, 32'd9);
        repeat (8) @(negedge clock);
        md.id_ex_mfhilo = 2'b01;
        #1;
        checks++; if (md.ex_if_stall !== 1'b1) begin errors++; $display("FAIL midrun_stall: got %b expected 1", md.ex_if_stall); end
        #1 reset = 1'b0;
        #1;
        checks++; if ({md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b expected 000", {md.ex_md_busy, md.ex_if_stall, md.ex_md_divzero}); end
        checks++; if ({md.ex_md_hi, md.ex_md_lo, md.ex_md_readvalue} !== 96'd0) begin errors++; $display("FAIL async_reset_regs: got %h expected 0", {md.ex_md_hi, md.ex_md_lo, md.ex_md_readvalue}); end
        exp_q.delete();
        drive_idle();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        issue(3'd2, 32'd2, 32'd2);
        wait_idle(cyc);
        e = exp_q.pop_front();
        checks++; if ({md.ex_md_hi, md.ex_md_lo} !== e || md.ex_md_lo !== 32'd4) begin errors++; $display("FAIL post_reset_multu: got %h expected %h", {md.ex_md_hi, md.ex_md_lo}, e); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_multu();
        test_signed();
        test_stall();
        test_divzero();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
